hours_register: RTL and testbench
=================================

# hours_register

Hours digit register for the digital clock datapath. It holds the current hour as a 24-hour BCD count. The count advances one hour per enabled clock. It presents the hour either as 24-hour BCD (00–23) or as 12-hour BCD (12, 01–11) with an AM/PM flag. It sits downstream of the minutes rollover, which drives its enable, and feeds the display/digit-mux logic.

## Interface
Parameters: none.

One clock; reset is synchronous and active-high.

- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous active-high reset; forces hour to 00 (midnight)
- en  input  1  increment enable; one-hour advance per rising edge while high
- military_time  input  1  display mode: 1 = 24-hour, 0 = 12-hour
- pm  output  1  1 when internal hour is 12–23, in both modes
- data_msd  output  4  BCD tens digit of displayed hour
- data_lsd  output  4  BCD units digit of displayed hour

## Operation
- State: a 24-hour BCD count, tens digit 0–2 and units digit 0–9. Only the values 00–23 are legal.
- Reset has priority over en. On reset the count becomes 00.
- With en=1 and reset=0, the count increments by one hour:
  - units 9 → 0 with tens+1
  - 23 → 00, which is day wrap-around
- With en=0 the count holds indefinitely.
- 24-hour mode (military_time=1): data_msd/data_lsd equal the internal count directly (00–23).
- 12-hour mode (military_time=0):
  - internal 00 → 12, pm=0
  - 01–09 → 01–09, pm=0
  - 10–11 → 10–11, pm=0
  - 12 → 12, pm=1
  - 13–21 → 01–09, pm=1
  - 22–23 → 10–11, pm=1
- The 12-hour units digit is computed in BCD; no binary intermediate is needed. Subtracting 12 in BCD:
  - 13–19 → 01–07
  - 20–21 → 08–09
  - 22–23 → 10–11
- Mode is a pure display transform. Toggling military_time never modifies or loses the stored count. Toggling back restores the previous representation exactly.
- Illegal internal states (unreachable) are not recovered specially; reset clears them.

## Timing
- Count register updates on the rising clk edge. Increment latency is one cycle from the en sample.
- Outputs are combinational from the count register and military_time.
  - A mode change is visible in the same cycle, with no clock needed.
  - A count change is visible immediately after the edge.
- Reset values of the outputs:
  - 12-hour mode: data_msd=1, data_lsd=2, pm=0
  - 24-hour mode: data_msd=0, data_lsd=0, pm=0
- Simultaneous en and reset: reset wins, count = 00.
- Mode change coincident with an increment edge: the new count is shown in the new mode; no glitch in state.

## Structure
- Shared clock package: constants HOURS_MAX_TENS=2, HOURS_MAX_UNITS_AT_MAX_TENS=3, NOON_TENS=1, NOON_UNITS=2, and a 4-bit BCD digit typedef. These are reused by the minutes/seconds registers.
- One sub-module: hours_12h_decode. It is combinational; inputs are the 24-hour BCD tens/units; outputs are the 12-hour BCD tens/units and pm.
- The top-level block contains the counter, the reset/enable logic, and the mode mux between the raw count and the decoder output.

## Test plan
- Hold: after reset, en=0 for 10 cycles → outputs stay 12 AM (12-hour mode), i.e. msd=1, lsd=2, pm=0.
- 12-hour sweep: military_time=0, en=1 for 24 cycles from 00 → sequence 01..11 AM, 12 PM, 01..11 PM, 12 AM. pm rises exactly on the 12 PM step and falls on the wrap to 12 AM.
- 24-hour sweep: military_time=1, en=1 for 24 cycles → 01..23, then 00. pm=1 exactly for 12–23. Digit carry checked at 09→10 and 19→20.
- Mode toggle without losing state: at internal 15, military_time 1→0 → shows 03 pm=1 in the same cycle. Back to 1 → shows 15; the count is unchanged across the toggle.
- Midnight/noon edge toggles: at internal 00 and at 12, toggle the mode → 00↔12 AM, and 12↔12 PM.
- Reset mid-count: at internal 17 with en=1, assert reset for one edge → count 00. Reset takes priority over en. The increment resumes from 00 on the next enabled edge.

Source files
------------

// File: rtl/hours_register_pkg.sv
// Shared clock datapath constants and BCD digit type.
// Reused by the hours, minutes and seconds registers.
package hours_register_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t HOURS_MAX_TENS              = 4'd2;
  localparam bcd_t HOURS_MAX_UNITS_AT_MAX_TENS = 4'd3;
  localparam bcd_t NOON_TENS                   = 4'd1;
  localparam bcd_t NOON_UNITS                  = 4'd2;

endpackage

// File: rtl/hours_12h_decode.sv
// 24-hour BCD to 12-hour BCD with AM/PM flag.
// Pure BCD arithmetic; no binary intermediate.
module hours_12h_decode
  import hours_register_pkg::*;
(
  input  bcd_t i_tens,
  input  bcd_t i_units,
  output bcd_t o_tens,
  output bcd_t o_units,
  output logic o_pm
);

  logic w_zero;
  logic w_am_teen;
  logic w_pm_teen;

  assign w_zero    = (i_tens == 4'd0) && (i_units == 4'd0);
  assign w_am_teen = (i_tens == NOON_TENS) && (i_units < NOON_UNITS);
  assign w_pm_teen = (i_tens == NOON_TENS) && (i_units >= NOON_UNITS);

  assign o_pm = w_pm_teen || (i_tens == HOURS_MAX_TENS);

  always_comb begin
    o_tens  = i_tens;
    o_units = i_units;
    unique case (1'b1)
      w_zero: begin
        o_tens  = NOON_TENS;
        o_units = NOON_UNITS;
      end
      (i_tens == 4'd0) && !w_zero: begin
        o_tens  = 4'd0;
        o_units = i_units;
      end
      w_am_teen: begin
        o_tens  = NOON_TENS;
        o_units = i_units;
      end
      w_pm_teen && (i_units == NOON_UNITS): begin
        o_tens  = NOON_TENS;
        o_units = NOON_UNITS;
      end
      // 13-19 -> 01-07
      w_pm_teen && (i_units != NOON_UNITS): begin
        o_tens  = 4'd0;
        o_units = i_units - 4'd2;
      end
      // 20-21 -> 08-09
      (i_tens == HOURS_MAX_TENS) && (i_units < 4'd2): begin
        o_tens  = 4'd0;
        o_units = i_units + 4'd8;
      end
      (i_tens == HOURS_MAX_TENS) && (i_units >= 4'd2): begin
        o_tens  = 4'd1;
        o_units = i_units - 4'd2;
      end
      default: begin
        o_tens  = i_tens;
        o_units = i_units;
      end
    endcase
  end

endmodule

// File: rtl/hours_register.sv
// Hours register: 24-hour BCD count with 12/24-hour display mux.
// Advances one hour per enabled clock, wraps 23 -> 00.
module hours_register
  import hours_register_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       military_time,
  output logic       pm,
  output logic [3:0] data_msd,
  output logic [3:0] data_lsd
);

  bcd_t r_tens;
  bcd_t r_units;
  bcd_t w_tens_12;
  bcd_t w_units_12;
  logic w_pm;
  logic w_wrap;

  assign w_wrap = (r_tens == HOURS_MAX_TENS) &&
                  (r_units == HOURS_MAX_UNITS_AT_MAX_TENS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tens  <= 4'd0;
      r_units <= 4'd0;
    end else if (en) begin
      if (w_wrap) begin
        r_tens  <= 4'd0;
        r_units <= 4'd0;
      end else if (r_units == 4'd9) begin
        r_tens  <= r_tens + 4'd1;
        r_units <= 4'd0;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

  hours_12h_decode u_dec (
    .i_tens  (r_tens),
    .i_units (r_units),
    .o_tens  (w_tens_12),
    .o_units (w_units_12),
    .o_pm    (w_pm)
  );

  assign pm       = w_pm;
  assign data_msd = military_time ? r_tens  : w_tens_12;
  assign data_lsd = military_time ? r_units : w_units_12;

endmodule

// File: tb/tb_hours_register.sv
// Self-checking bench for hours_register.
// Integer-hour reference model plus literal spot checks.
module tb_hours_register;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       military_time = 1'b0;
  logic       pm;
  logic [3:0] data_msd;
  logic [3:0] data_lsd;

  int checks = 0;
  int failures = 0;
  int hour = 0;
  bit chk_on = 1'b0;

  hours_register dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .military_time (military_time),
    .pm            (pm),
    .data_msd      (data_msd),
    .data_lsd      (data_lsd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) hour <= 0;
    else if (en) hour <= (hour + 1) % 24;
  end

  function automatic void model(input int h, input bit mt,
                                output int msd, output int lsd,
                                output int p);
    int d;
    p = (h >= 12) ? 1 : 0;
    if (mt) d = h;
    else d = (h % 12 == 0) ? 12 : h % 12;
    msd = d / 10;
    lsd = d % 10;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (hour=%0d mt=%0b)",
               nm, act, exp, hour, military_time);
    end
  endtask

  task automatic chk_model(input string tag);
    int m, l, p;
    model(hour, military_time, m, l, p);
    chk({tag, "_msd"}, int'(data_msd), m);
    chk({tag, "_lsd"}, int'(data_lsd), l);
    chk({tag, "_pm"}, int'(pm), p);
  endtask

  task automatic chk_lit(input string tag, input int m,
                         input int l, input int p);
    chk({tag, "_msd"}, int'(data_msd), m);
    chk({tag, "_lsd"}, int'(data_lsd), l);
    chk({tag, "_pm"}, int'(pm), p);
  endtask

  always @(negedge clk) begin
    if (chk_on) chk_model("cyc");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    chk_on = 1'b1;
    chk_lit("rst12", 1, 2, 0);
    military_time = 1'b1;
    #1 chk_lit("rst24", 0, 0, 0);
    military_time = 1'b0;

    step(10);
    chk_lit("hold", 1, 2, 0);

    en = 1'b1;
    step(11);
    chk_lit("11am", 1, 1, 0);
    step(1);
    chk_lit("12pm", 1, 2, 1);
    step(1);
    chk_lit("1pm", 0, 1, 1);
    step(10);
    chk_lit("11pm", 1, 1, 1);
    step(1);
    chk_lit("12am", 1, 2, 0);

    military_time = 1'b1;
    step(10);
    chk_lit("h10", 1, 0, 0);
    step(10);
    chk_lit("h20", 2, 0, 1);
    step(3);
    chk_lit("h23", 2, 3, 1);
    step(1);
    chk_lit("h00", 0, 0, 0);

    step(15);
    en = 1'b0;
    chk_lit("h15", 1, 5, 1);
    military_time = 1'b0;
    #1 chk_lit("t15_12", 0, 3, 1);
    military_time = 1'b1;
    #1 chk_lit("t15_24", 1, 5, 1);
    step(2);
    chk_lit("hold15", 1, 5, 1);

    en = 1'b1;
    step(9);
    en = 1'b0;
    chk_lit("mid24", 0, 0, 0);
    military_time = 1'b0;
    #1 chk_lit("mid12", 1, 2, 0);
    en = 1'b1;
    step(12);
    en = 1'b0;
    chk_lit("noon12", 1, 2, 1);
    military_time = 1'b1;
    #1 chk_lit("noon24", 1, 2, 1);

    en = 1'b1;
    step(5);
    chk_lit("h17", 1, 7, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_lit("rstmid", 0, 0, 0);
    step(1);
    chk_lit("resume", 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      reset = 1'($urandom_range(0, 49) == 0);
      military_time = 1'($urandom_range(0, 1));
      #2 chk_model("rnd_mid");
      military_time = 1'($urandom_range(0, 1));
      step(1);
    end
    reset = 1'b0;
    en = 1'b0;
    step(2);
    chk_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
